// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                |
// | Description : ID-stage hazard controller for the 5-stage MIPS-subset     |
// |               core. Stalls on load-use dependencies, flushes wrong-path  |
// |               instructions on a redirect from EX, and freezes the whole  |
// |               pipe while external memory is not ready.                   |
// | Parameters  : LU_STALL_CYCLES - bubbles per load-use hazard (1..7)       |
// | Ports       : clk, rst              - clock, synchronous active-high rst |
// |               id_* / ex_*           - ID and EX instruction info         |
// |               ex_redirect           - taken branch/jump resolved in EX   |
// |               ext_stall             - imem/dmem not ready                |
// |               pc_we, ifid_we        - pipeline register load enables     |
// |               ifid_flush, idex_flush- bubble insertion controls          |
// |               state                 - 0 = RUN, 1 = LU_STALL              |
// |               perf_stall_cnt/flush  - performance counters               |
// | Macro       : HAZARD_PERF_EN - builds the perf counters; when undefined  |
// |               both counter ports read 32'h0 and no flops are built.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
    parameter int unsigned LU_STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_id,
    input  logic [4:0]  id_rs2_id,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_we_regfile,
    input  logic [4:0]  ex_rdst_id,
    input  logic        ex_redirect,
    input  logic        ext_stall,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        state,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } state_t;

    // Remaining stall cycles after the first one, loaded on entry to LU_STALL.
    localparam logic [2:0] c_lu_load = 3'(LU_STALL_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_lu_cnt;
    logic       w_lu_hit;
    logic       w_stall;

    // $0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign w_lu_hit = id_valid && ex_valid && ex_is_load && ex_we_regfile &&
                      (ex_rdst_id != 5'd0) &&
                      ((id_uses_rs && (id_rs1_id == ex_rdst_id)) ||
                       (id_uses_rt && (id_rs2_id == ex_rdst_id)));

    // The hazard is only looked at in RUN; once in LU_STALL the counter alone
    // decides when the ID instruction may advance.
    assign w_stall = ((r_state == ST_RUN) && w_lu_hit) || (r_state == ST_LU_STALL);

    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (rst) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (ext_stall) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_stall) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_lu_cnt <= 3'd0;
        end else if (!ext_stall) begin
            if (ex_redirect) begin
                // The redirect squashes the dependent instruction as well.
                r_state  <= ST_RUN;
                r_lu_cnt <= 3'd0;
            end else if (r_state == ST_RUN) begin
                if (w_lu_hit && (LU_STALL_CYCLES > 1)) begin
                    r_state  <= ST_LU_STALL;
                    r_lu_cnt <= c_lu_load;
                end
            end else begin
                r_lu_cnt <= r_lu_cnt - 3'd1;
                if (r_lu_cnt == 3'd1) begin
                    r_state <= ST_RUN;
                end
            end
        end
    end

    assign state = r_state;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    // Stall count covers both load-use bubbles and external freezes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall_cnt <= 32'd0;
            r_perf_flush_cnt <= 32'd0;
        end else begin
            if (!pc_we) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (ex_redirect && !ext_stall) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hazard_ctrl                                             |
// | Description : Self-checking bench for hazard_ctrl. Two instances share   |
// |               one stimulus: dut_a with LU_STALL_CYCLES = 1 and dut_b     |
// |               with LU_STALL_CYCLES = 3. A behavioural model tracks the   |
// |               number of stall cycles still owed per instance.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1_id;
    logic [4:0]  id_rs2_id;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_valid;
    logic        ex_is_load;
    logic        ex_we_regfile;
    logic [4:0]  ex_rdst_id;
    logic        ex_redirect;
    logic        ext_stall;

    logic        a_pc_we, a_ifid_we, a_ifid_flush, a_idex_flush, a_state;
    logic [31:0] a_pstall, a_pflush;
    logic        b_pc_we, b_ifid_we, b_ifid_flush, b_idex_flush, b_state;
    logic [31:0] b_pstall, b_pflush;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_STALL_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_we_regfile(ex_we_regfile),
        .ex_rdst_id(ex_rdst_id), .ex_redirect(ex_redirect), .ext_stall(ext_stall),
        .pc_we(a_pc_we), .ifid_we(a_ifid_we), .ifid_flush(a_ifid_flush),
        .idex_flush(a_idex_flush), .state(a_state),
        .perf_stall_cnt(a_pstall), .perf_flush_cnt(a_pflush)
    );

    hazard_ctrl #(.LU_STALL_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_we_regfile(ex_we_regfile),
        .ex_rdst_id(ex_rdst_id), .ex_redirect(ex_redirect), .ext_stall(ext_stall),
        .pc_we(b_pc_we), .ifid_we(b_ifid_we), .ifid_flush(b_ifid_flush),
        .idex_flush(b_idex_flush), .state(b_state),
        .perf_stall_cnt(b_pstall), .perf_flush_cnt(b_pflush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // rem_x = stall cycles still owed after the current one.
    int          rem_a = 0, rem_b = 0;
    logic [31:0] ps_a = 0, pf_a = 0, ps_b = 0, pf_b = 0;

    function automatic bit hit();
        bit m_rs = id_uses_rs && (id_rs1_id == ex_rdst_id);
        bit m_rt = id_uses_rt && (id_rs2_id == ex_rdst_id);
        return id_valid && ex_valid && ex_is_load && ex_we_regfile &&
               (ex_rdst_id != 0) && (m_rs || m_rt);
    endfunction

    // {pc_we, ifid_we, ifid_flush, idex_flush}
    function automatic logic [3:0] ctrl(input int rem);
        if (rst)         return 4'b0011;
        if (ext_stall)   return 4'b0000;
        if (ex_redirect) return 4'b1111;
        if (rem > 0 || hit()) return 4'b0001;
        return 4'b1100;
    endfunction

    function automatic int nxt(input int rem, input int n);
        if (rst)         return 0;
        if (ext_stall)   return rem;
        if (ex_redirect) return 0;
        if (rem > 0)     return rem - 1;
        if (hit())       return n - 1;
        return 0;
    endfunction

    function automatic logic [31:0] nps(input logic [31:0] c, input int rem);
        logic [3:0] e = ctrl(rem);
        if (rst) return 0;
        return e[3] ? c : c + 1;
    endfunction

    function automatic logic [31:0] npf(input logic [31:0] c);
        if (rst) return 0;
        return (ex_redirect && !ext_stall) ? c + 1 : c;
    endfunction

    always @(posedge clk) begin
        ps_a  <= nps(ps_a, rem_a);
        ps_b  <= nps(ps_b, rem_b);
        pf_a  <= npf(pf_a);
        pf_b  <= npf(pf_b);
        rem_a <= nxt(rem_a, 1);
        rem_b <= nxt(rem_b, 3);
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] ea;
            logic [3:0] eb;
            ea = ctrl(rem_a);
            eb = ctrl(rem_b);
            chk("a.pc_we",      32'(a_pc_we),      32'(ea[3]));
            chk("a.ifid_we",    32'(a_ifid_we),    32'(ea[2]));
            chk("a.ifid_flush", 32'(a_ifid_flush), 32'(ea[1]));
            chk("a.idex_flush", 32'(a_idex_flush), 32'(ea[0]));
            chk("a.state",      32'(a_state),      32'(rem_a > 0));
            chk("b.pc_we",      32'(b_pc_we),      32'(eb[3]));
            chk("b.ifid_we",    32'(b_ifid_we),    32'(eb[2]));
            chk("b.ifid_flush", 32'(b_ifid_flush), 32'(eb[1]));
            chk("b.idex_flush", 32'(b_idex_flush), 32'(eb[0]));
            chk("b.state",      32'(b_state),      32'(rem_b > 0));
`ifdef HAZARD_PERF_EN
            chk("a.perf_stall", a_pstall, ps_a);
            chk("a.perf_flush", a_pflush, pf_a);
            chk("b.perf_stall", b_pstall, ps_b);
            chk("b.perf_flush", b_pflush, pf_b);
`else
            chk("a.perf_stall", a_pstall, 32'h0);
            chk("b.perf_flush", b_pflush, 32'h0);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        id_valid = 0; id_rs1_id = 0; id_rs2_id = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_valid = 0; ex_is_load = 0; ex_we_regfile = 0; ex_rdst_id = 0;
        ex_redirect = 0; ext_stall = 0;
    endtask

    // lw rd in EX, ID instruction reading rd through rs or rt
    task automatic load_use(input logic [4:0] rd, input bit via_rt);
        idle();
        ex_valid = 1; ex_is_load = 1; ex_we_regfile = 1; ex_rdst_id = rd;
        id_valid = 1;
        if (via_rt) begin id_uses_rt = 1; id_rs2_id = rd; id_rs1_id = 5'd2; id_uses_rs = 1; end
        else        begin id_uses_rs = 1; id_rs1_id = rd; end
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; next(); rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        next();
        chk_en = 1;
        // Reset held for 2 cycles
        @(negedge clk);
        chk("rst.pc_we", 32'(a_pc_we), 32'd0);
        chk("rst.ifid_flush", 32'(a_ifid_flush), 32'd1);
        chk("rst.idex_flush", 32'(b_idex_flush), 32'd1);
        next();
        rst = 0;
        @(negedge clk);
        chk("idle.pc_we", 32'(a_pc_we), 32'd1);
        chk("idle.state", 32'(b_state), 32'd0);
        next();

        // Load-use, LU_STALL_CYCLES = 1
        load_use(5'd8, 1'b0);
        @(negedge clk);
        chk("lu1.pc_we", 32'(a_pc_we), 32'd0);
        chk("lu1.idex_flush", 32'(a_idex_flush), 32'd1);
        next();
        ex_valid = 0;
        @(negedge clk);
        chk("lu1.after.pc_we", 32'(a_pc_we), 32'd1);
        next();
        do_reset();
        load_use(5'd0, 1'b0);
        @(negedge clk);
        chk("lu.r0.pc_we", 32'(a_pc_we), 32'd1);
        chk("lu.r0.b_pc_we", 32'(b_pc_we), 32'd1);
        next();

        // LU_STALL_CYCLES = 3 via rt
        do_reset();
        load_use(5'd5, 1'b1);
        @(negedge clk);
        chk("lu3.c1.pc_we", 32'(b_pc_we), 32'd0);
        chk("lu3.c1.state", 32'(b_state), 32'd0);
        next(); ex_valid = 0;
        @(negedge clk);
        chk("lu3.c2.state", 32'(b_state), 32'd1);
        chk("lu3.c2.pc_we", 32'(b_pc_we), 32'd0);
        next();
        @(negedge clk);
        chk("lu3.c3.state", 32'(b_state), 32'd1);
        next();
        @(negedge clk);
        chk("lu3.c4.state", 32'(b_state), 32'd0);
        chk("lu3.c4.pc_we", 32'(b_pc_we), 32'd1);
        next();

        // Redirect with a simultaneous load-use hazard
        do_reset();
        load_use(5'd9, 1'b0);
        ex_redirect = 1;
        @(negedge clk);
        chk("redir.pc_we", 32'(b_pc_we), 32'd1);
        chk("redir.ifid_flush", 32'(b_ifid_flush), 32'd1);
        chk("redir.idex_flush", 32'(b_idex_flush), 32'd1);
        next(); idle();
        @(negedge clk);
        chk("redir.after.pc_we", 32'(b_pc_we), 32'd1);
        chk("redir.after.state", 32'(b_state), 32'd0);
`ifdef HAZARD_PERF_EN
        chk("redir.perf_flush", b_pflush, 32'd1);
`endif
        next();

        // Freeze on the 2nd stall cycle for 4 cycles
        do_reset();
        load_use(5'd7, 1'b0);
        next();
        ex_valid = 0; ext_stall = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("frz.pc_we", 32'(b_pc_we), 32'd0);
            chk("frz.idex_flush", 32'(b_idex_flush), 32'd0);
            next();
        end
        ext_stall = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("frz.resume.pc_we", 32'(b_pc_we), 32'd0);
            chk("frz.resume.idex_flush", 32'(b_idex_flush), 32'd1);
            next();
        end
        @(negedge clk);
        chk("frz.done.pc_we", 32'(b_pc_we), 32'd1);
`ifdef HAZARD_PERF_EN
        chk("frz.perf_stall", b_pstall, 32'd7);
`endif
        next();

        // Reset in the middle of LU_STALL
        load_use(5'd11, 1'b0);
        next();
        idle(); rst = 1;
        next();
        rst = 0;
        @(negedge clk);
        chk("rstmid.state", 32'(b_state), 32'd0);
        chk("rstmid.perf_stall", b_pstall, 32'd0);
        next();

        // Randomized traffic, small register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 63) == 0);
            ext_stall     = ($urandom_range(0, 7) == 0);
            ex_redirect   = ($urandom_range(0, 9) == 0);
            id_valid      = ($urandom_range(0, 7) != 0);
            ex_valid      = ($urandom_range(0, 7) != 0);
            ex_is_load    = ($urandom_range(0, 2) != 0);
            ex_we_regfile = ($urandom_range(0, 5) != 0);
            id_uses_rs    = 1'($urandom_range(0, 1));
            id_uses_rt    = 1'($urandom_range(0, 1));
            id_rs1_id     = 5'($urandom_range(0, 3));
            id_rs2_id     = 5'($urandom_range(0, 3));
            ex_rdst_id    = 5'($urandom_range(0, 3));
            next();
        end

        idle();
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS-subset core. It watches the decoded instruction in ID and the instruction in EX, and drives the write-enable and flush controls of the PC, IF/ID and ID/EX registers. Its jobs are to stall on load-use dependencies, flush wrong-path instructions on a taken branch or jump, and freeze the pipe on an external memory stall. It sits beside the decoder in the ID stage; its outputs gate the pipeline registers directly.

## Interface
Parameters:
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal range 1..7).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_id  in  5  rs field of the instruction in ID.
- id_rs2_id  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw).
- ex_valid  in  1  EX holds a real instruction.
- ex_is_load  in  1  EX instruction is lw (wbsel == 1).
- ex_we_regfile  in  1  EX instruction writes the register file.
- ex_rdst_id  in  5  destination register of the EX instruction.
- ex_redirect  in  1  taken beq, j, jal or jr resolved in EX this cycle.
- ext_stall  in  1  imem/dmem not ready; freeze the whole pipe.
- pc_we  out  1  PC register load enable.
- ifid_we  out  1  IF/ID register load enable.
- ifid_flush  out  1  clear IF/ID to a bubble.
- idex_flush  out  1  load a bubble into ID/EX (we_regfile = we_dmem = 0, jump_type = NOP).
- state  out  1  0 = RUN, 1 = LU_STALL.
- perf_stall_cnt  out  32  stall cycles counted (see Configuration).
- perf_flush_cnt  out  32  redirect flushes counted (see Configuration).

## Operation
- Load-use hazard `lu_hit` is asserted when all of these hold:
  - id_valid, ex_valid, ex_is_load and ex_we_regfile;
  - ex_rdst_id != 0;
  - (id_uses_rs && id_rs1_id == ex_rdst_id) || (id_uses_rt && id_rs2_id == ex_rdst_id).
- Internal state: a 1-bit FSM and a 3-bit down-counter `lu_cnt`.
- Output priority: rst > ext_stall > ex_redirect > stall condition > normal.
  - rst: pc_we = 0, ifid_we = 0, ifid_flush = 1, idex_flush = 1.
  - ext_stall: all four controls 0. The FSM and lu_cnt hold; the perf counters still count.
  - ex_redirect: pc_we = 1, ifid_we = 1, ifid_flush = 1, idex_flush = 1. Next state is RUN and lu_cnt is cleared.
  - RUN && lu_hit, or state LU_STALL: pc_we = 0, ifid_we = 0, ifid_flush = 0, idex_flush = 1.
  - Otherwise: pc_we = 1, ifid_we = 1, both flushes 0.
- FSM transitions apply only when ext_stall = 0:
  - RUN, lu_hit and LU_STALL_CYCLES == 1: stay in RUN.
  - RUN, lu_hit and LU_STALL_CYCLES > 1: go to LU_STALL and load lu_cnt = LU_STALL_CYCLES - 1.
  - LU_STALL: decrement lu_cnt. When lu_cnt == 1, return to RUN on this edge.
  - lu_hit is not re-evaluated while in LU_STALL.
- Register $0 never creates a hazard.

## Timing
- Controls are combinational from the current state and inputs, valid in the same cycle as the hazard. There are no extra cycles of latency.
- Reset values: state = RUN, lu_cnt = 0, perf counters = 0.
- A load-use hazard costs exactly LU_STALL_CYCLES cycles, not counting frozen cycles. The ID instruction advances on the following edge.
- ex_redirect and lu_hit in the same cycle: the redirect wins and no stall is recorded.
- ext_stall asserted mid-LU_STALL: the remaining stall count is preserved and resumes when ext_stall drops.
- rst asserted mid-LU_STALL: the FSM returns to RUN on the next edge.

## Configuration
- HAZARD_PERF_EN:
  - Defined: perf_stall_cnt increments on every non-reset cycle where pc_we = 0 (stall or freeze). perf_flush_cnt increments on every ex_redirect cycle with ext_stall = 0. Both wrap modulo 2^32 and clear on rst.
  - Undefined: both ports are tied to 32'h0 and no counter flops are built.

## Test plan
- Reset: rst = 1 for 2 cycles -> pc_we = 0, ifid_we = 0, ifid_flush = 1, idex_flush = 1, state = 0. After release with idle inputs -> pc_we = 1, ifid_we = 1, no flushes.
- Load-use: EX lw to $8, ID add with rs = $8 -> exactly one cycle of pc_we = 0, ifid_we = 0, idex_flush = 1, then normal operation. The same stimulus with ex_rdst_id = 0 produces no stall.
- LU_STALL_CYCLES = 3: lw $5 in EX, beq in ID using rt = $5 -> 3 consecutive stall cycles. state = 1 on cycles 2 and 3, then 0.
- Redirect: ex_redirect = 1 while lu_hit = 1 -> ifid_flush = 1, idex_flush = 1, pc_we = 1 for one cycle. No stall follows; perf_flush_cnt goes from 0 to 1.
- Freeze: with LU_STALL_CYCLES = 3, assert ext_stall for 4 cycles on the 2nd stall cycle -> all controls are 0 during the freeze, then 2 more stall cycles follow. perf_stall_cnt = 7 when HAZARD_PERF_EN is defined.
- Reset mid-stall: rst during LU_STALL -> state = 0 on the next cycle and the perf counters read 0.
